// File: rtl/alu8bit.sv
`default_nettype none
// ============================================================================
// Module   : alu8bit
// Brief    : 8-bit unsigned ALU, single-cycle registered result and C/Z flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  Opcode,
    input  logic [7:0]  Operand1,
    input  logic [7:0]  Operand2,
    output logic [15:0] Result,
    output logic        flagC,
    output logic        flagZ
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    logic [8:0]  sum;
    logic [7:0]  diff;
    logic [15:0] product;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        div_by_zero;
    logic [15:0] next_result;
    logic        next_c;

    assign sum         = {1'b0, Operand1} + {1'b0, Operand2};
    assign diff        = Operand1 - Operand2;
    assign product     = {8'h00, Operand1} * {8'h00, Operand2};
    assign div_by_zero = (Operand2 == 8'h00);

    // Divider is purely combinational; the zero-divisor path never reaches it.
    always_comb begin
        quot = 8'hFF;
        rem  = 8'hFF;
        if (!div_by_zero) begin
            quot = Operand1 / Operand2;
            rem  = Operand1 % Operand2;
        end
    end

    always_comb begin
        next_result = 16'h0000;
        next_c      = 1'b0;
        case (Opcode)
            OP_ADD: begin
                next_result = {7'b0, sum};
                next_c      = sum[8];
            end
            OP_SUB: begin
                next_result = {8'h00, diff};
                next_c      = (Operand2 > Operand1);
            end
            OP_MUL: begin
                next_result = product;
                next_c      = (product[15:8] != 8'h00);
            end
            OP_DIV: begin
                next_result = {rem, quot};
                next_c      = div_by_zero;
            end
            OP_AND: next_result = {8'h00, Operand1 & Operand2};
            OP_OR:  next_result = {8'h00, Operand1 | Operand2};
            OP_XOR: next_result = {8'h00, Operand1 ^ Operand2};
            OP_NOT: next_result = {8'h00, ~Operand1};
            default: begin
                next_result = 16'h0000;
                next_c      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result <= 16'h0000;
            flagC  <= 1'b0;
            flagZ  <= 1'b1;
        end else begin
            Result <= next_result;
            flagC  <= next_c;
            flagZ  <= (next_result == 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu8bit
// Brief    : Scoreboard bench for alu8bit: directed vectors, reset cases, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu8bit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  Opcode;
    logic [7:0]  Operand1;
    logic [7:0]  Operand2;
    logic [15:0] Result;
    logic        flagC;
    logic        flagZ;

    typedef struct {
        logic [17:0] exp;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    alu8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result   (Result),
        .flagC    (flagC),
        .flagZ    (flagZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected packed as {result, C, Z}.
    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                     tag, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Independent reference written with integer arithmetic.
    function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 255); end
            3'd1: begin r = (ia - ib + 256) % 256; c = (ib > ia); end
            3'd2: begin r = ia * ib; c = (r > 255); end
            3'd3: begin
                if (ib == 0) begin r = 65535; c = 1'b1; end
                else r = (ia % ib) * 256 + (ia / ib);
            end
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = 255 - ia;
        endcase
        return {r[15:0], c, (r == 0)};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [17:0] exp, input string tag);
        sb_entry_t e;
        @(negedge clk);
        Opcode   = op;
        Operand1 = a;
        Operand2 = b;
        rst_n    = 1'b1;
        e.exp    = exp;
        e.tag    = tag;
        sb_q.push_back(e);
    endtask

    task automatic collect();
        sb_entry_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 18'h0, 18'h1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {Result, flagC, flagZ}, e.exp);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [17:0] exp, input string tag);
        drive(op, a, b, exp, tag);
        collect();
    endtask

    logic [17:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = {16'h00FF, 1'b0, 1'b0};
        sweep_exp[1] = {16'h0055, 1'b0, 1'b0};
        sweep_exp[2] = {16'h3872, 1'b1, 1'b0};
        sweep_exp[3] = {16'h0002, 1'b0, 1'b0};
        sweep_exp[4] = {16'h0000, 1'b0, 1'b1};
        sweep_exp[5] = {16'h00FF, 1'b0, 1'b0};
        sweep_exp[6] = {16'h00FF, 1'b0, 1'b0};
        sweep_exp[7] = {16'h0055, 1'b0, 1'b0};

        rst_n    = 1'b1;
        Opcode   = 3'd0;
        Operand1 = 8'hAA;
        Operand2 = 8'h55;
        #1 rst_n = 1'b0;
        #1 check("reset_async", {Result, flagC, flagZ}, {16'h0000, 1'b0, 1'b1});
        @(posedge clk);
        #1 check("reset_hold_edge", {Result, flagC, flagZ}, {16'h0000, 1'b0, 1'b1});

        for (int i = 0; i < 8; i++)
            run(3'(i), 8'hAA, 8'h55, sweep_exp[i], $sformatf("sweep_op%0d", i));

        run(3'd0, 8'hFF, 8'h01, {16'h0100, 1'b1, 1'b0}, "add_carry");
        run(3'd1, 8'h00, 8'h01, {16'h00FF, 1'b1, 1'b0}, "sub_borrow");
        run(3'd1, 8'h55, 8'h55, {16'h0000, 1'b0, 1'b1}, "sub_zero");
        run(3'd2, 8'hFF, 8'hFF, {16'hFE01, 1'b1, 1'b0}, "mul_ff");
        run(3'd2, 8'h0F, 8'h0F, {16'h00E1, 1'b0, 1'b0}, "mul_0f");
        run(3'd3, 8'h07, 8'h00, {16'hFFFF, 1'b1, 1'b0}, "div_zero");
        run(3'd3, 8'h07, 8'h03, {16'h0102, 1'b0, 1'b0}, "div_7_3");

        // Mid-stream reset: the AND in flight must be discarded.
        for (int i = 0; i < 4; i++)
            run(3'(i), 8'hAA, 8'h55, sweep_exp[i], $sformatf("sweep2_op%0d", i));
        drive(3'd4, 8'hAA, 8'h55, sweep_exp[4], "sweep2_op4");
        #2 rst_n = 1'b0;
        void'(sb_q.pop_front());
        #1 check("midreset_async", {Result, flagC, flagZ}, {16'h0000, 1'b0, 1'b1});
        @(posedge clk);
        #1 check("midreset_hold", {Result, flagC, flagZ}, {16'h0000, 1'b0, 1'b1});
        for (int i = 5; i < 8; i++)
            run(3'(i), 8'hAA, 8'h55, sweep_exp[i], $sformatf("after_release_op%0d", i));

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            b  = (i % 6 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            run(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu8bit.md
ALU8BIT -- requirements
Module: ALU8bit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Opcode  input  3  operation select; sampled each rising edge.
REQ-005 Operand1  input  8  unsigned operand A.
REQ-006 Operand2  input  8  unsigned operand B.
REQ-007 Result  output  16  registered operation result.
REQ-008 flagC  output  1  registered carry/borrow/overflow/error flag.
REQ-009 flagZ  output  1  registered zero flag.

Function
REQ-010 Inputs SHALL be sampled on each rising clk edge; Result, flagC and flagZ SHALL update on that same edge, giving 1-cycle latency with a new result every cycle (no handshake, no stall).
REQ-011 The datapath is unsigned throughout. A = Operand1 and B = Operand2.
REQ-012 Opcode 000, ADD: Result SHALL be {7'b0, A+B as 9 bits}; flagC SHALL be bit 8 of the sum.
REQ-013 Opcode 001, SUB: Result[7:0] SHALL be (A-B) mod 256 and Result[15:8] SHALL be 0; flagC SHALL be 1 if and only if B > A (borrow).
REQ-014 Opcode 010, MUL: Result SHALL be the full 16-bit product A*B; flagC SHALL be 1 if and only if Result[15:8] != 0.
REQ-015 Opcode 011, DIV: Result[7:0] SHALL be A/B (quotient) and Result[15:8] SHALL be A%B (remainder); flagC SHALL be 0.
REQ-016 DIV with B = 0: Result SHALL be 16'hFFFF and flagC SHALL be 1 (divide error). flagZ SHALL be 0.
REQ-017 Opcode 100, AND: Result SHALL be {8'h00, A&B}; flagC SHALL be 0.
REQ-018 Opcode 101, OR: Result SHALL be {8'h00, A|B}; flagC SHALL be 0.
REQ-019 Opcode 110, XOR: Result SHALL be {8'h00, A^B}; flagC SHALL be 0.
REQ-020 Opcode 111, NOT: Result SHALL be {8'h00, ~A}; B SHALL be ignored; flagC SHALL be 0.
REQ-021 For every opcode, flagZ SHALL be 1 if and only if the 16-bit Result being registered equals 0.
REQ-022 Opcode or operand changes between edges SHALL affect only the next registered value. Outputs SHALL hold between edges.
REQ-023 All 8 opcode encodings are defined. X/Z inputs are outside scope.
REQ-024 DIV SHALL complete within the single cycle using combinational logic; no multicycle divider.

Reset
REQ-025 When rst_n = 0, Result SHALL be 16'h0000, flagC SHALL be 0 and flagZ SHALL be 1, immediately and independently of clk.
REQ-026 While rst_n = 0, the outputs SHALL hold their reset values and all clock edges SHALL be ignored.
REQ-027 The first rising edge with rst_n = 1 SHALL register the operation for the inputs present at that edge.
REQ-028 Reset asserted mid-sequence SHALL discard the in-flight result; no stale value SHALL appear after release.

Verification
REQ-029 Reset: rst_n = 0 at any time -> Result 0000, flagC 0, flagZ 1 without a clock edge.
REQ-030 Sweep with A = AA and B = 55, Opcode stepping 0 to 7 once per cycle, checking one cycle later:
- ADD -> 00FF, C0, Z0
- SUB -> 0055, C0, Z0
- MUL -> 3872, C1, Z0
- DIV -> 0002, C0, Z0
- AND -> 0000, C0, Z1
- OR -> 00FF, C0, Z0
- XOR -> 00FF, C0, Z0
- NOT -> 0055, C0, Z0
REQ-031 Carry and borrow: ADD FF+01 -> 0100, C1, Z0. SUB 00-01 -> 00FF, C1, Z0. SUB 55-55 -> 0000, C0, Z1.
REQ-032 Multiply extremes: MUL FF*FF -> FE01, C1. MUL 0F*0F -> 00E1, C0.
REQ-033 Divide: DIV 07/00 -> FFFF, C1, Z0. DIV 07/03 -> 0102, C0.
REQ-034 Reset mid-stream: assert rst_n between edges during the REQ-030 sweep -> outputs at reset values immediately. After release, the next edge yields the current opcode's result.
